// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state encodings for the registered ALU slice.
package alu_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_ADD  = 4'h0;
    localparam op_t OP_SUB  = 4'h1;
    localparam op_t OP_AND  = 4'h2;
    localparam op_t OP_OR   = 4'h3;
    localparam op_t OP_NOT  = 4'h4;
    localparam op_t OP_XOR  = 4'h5;
    localparam op_t OP_NOR  = 4'h6;
    localparam op_t OP_SHL  = 4'h7;
    localparam op_t OP_SHR  = 4'h8;
    localparam op_t OP_ASR  = 4'h9;
    localparam op_t OP_ROL  = 4'hA;
    localparam op_t OP_ROR  = 4'hB;
    localparam op_t OP_EQ   = 4'hC;
    localparam op_t OP_MUL  = 4'hD;
    localparam op_t OP_SLT  = 4'hE;
    localparam op_t OP_ZERO = 4'hF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_comb.sv
// Combinational decode of every single-cycle opcode; MUL and unused codes yield zero.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             ovf
);

    localparam int M = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, x} + {1'b0, y};
    assign diff = {1'b0, x} - {1'b0, y};

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (ctrl)
            OP_ADD: begin
                res   = sum[M:0];
                carry = sum[WIDTH];
                ovf   = (x[M] == y[M]) && (sum[M] != x[M]);
            end
            OP_SUB: begin
                // The extra MSB of the widened difference is the borrow.
                res   = diff[M:0];
                carry = diff[WIDTH];
                ovf   = (x[M] != y[M]) && (diff[M] != x[M]);
            end
            OP_AND:  res = x & y;
            OP_OR:   res = x | y;
            OP_NOT:  res = ~x;
            OP_XOR:  res = x ^ y;
            OP_NOR:  res = ~(x | y);
            OP_SHL:  res = y << x[SHW-1:0];
            OP_SHR:  res = y >> x[SHW-1:0];
            OP_ASR:  res = {x[M], x[M:1]};
            OP_ROL:  res = {x[M-1:0], x[M]};
            OP_ROR:  res = {x[0], x[M:1]};
            OP_EQ:   res = {{(WIDTH-1){1'b0}}, x == y};
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(x) < $signed(y)};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, status flags and a shift-add multiplier.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             ovf
);

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    logic [1:0]         state;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mplier;

    logic [WIDTH-1:0]   c_res;
    logic               c_carry;
    logic               c_ovf;

    logic out_free;
    logic accept;
    logic load_op;
    logic load_mul;

    alu_comb #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_comb (
        .ctrl  (ctrl),
        .x     (x),
        .y     (y),
        .res   (c_res),
        .carry (c_carry),
        .ovf   (c_ovf)
    );

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == ST_IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign load_op  = accept && (ctrl != OP_MUL);
    assign load_mul = (state == ST_DONE) && out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && (ctrl == OP_MUL)) begin
                        mcand  <= {{WIDTH{1'b0}}, x};
                        mplier <= y;
                        prod   <= '0;
                        cnt    <= '0;
                        state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    // Multiplicand walks left while the multiplier drains from its LSB.
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_free) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (load_op) begin
            out       <= c_res;
            carry     <= c_carry;
            zero      <= (c_res == '0);
            ovf       <= c_ovf;
            out_valid <= 1'b1;
        end else if (load_mul) begin
            out       <= prod[WIDTH-1:0];
            carry     <= |prod[2*WIDTH-1:WIDTH];
            zero      <= (prod[WIDTH-1:0] == '0);
            ovf       <= 1'b0;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
